// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button input stage.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat while a button is held).
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_W,
    HELD,
    REL_W
  } btn_state_t;

  localparam int unsigned DEF_NUM_BTN         = 5;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_CTR   = 4;

  // Width of a counter that must hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser, debounce FSM with saturating counter,
// registered level / press strobe / release strobe.
// Optional feature macro: BTN_REPEAT_EN adds auto-repeat pulses while held.
module debounce_cell
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o,
  output logic rel_o,
  output logic pulse_nxt_o
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q;
  logic        sync2_q;
  logic        s;
  btn_state_t  state_q;
  logic [CW-1:0] cnt_q;
  logic        level_q;
  logic        pulse_q;
  logic        rel_q;
  logic        press_done;
  logic        rel_done;
  logic        rep_fire;
  logic        pulse_d;
  logic        rel_d;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;

  // Accept conditions: the current sample is the last one needed.
  always_comb begin
    press_done = (state_q == PRESS_W) && s && (cnt_q == CNT_LAST);
    rel_done   = (state_q == REL_W) && !s && (cnt_q == CNT_LAST);
    pulse_d    = press_done | rep_fire;
    rel_d      = rel_done;
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned   RW      = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_q;
  logic          first_done_q;

  assign rep_fire = (state_q == HELD) && s &&
                    (rep_q == (first_done_q ? RP_LAST : RD_LAST));

  // Repeat timer: runs only while held with the input still pressed; any
  // excursion out of that condition restarts the initial delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q        <= '0;
      first_done_q <= 1'b0;
    end else if ((state_q == HELD) && s) begin
      if (rep_fire) begin
        rep_q        <= '0;
        first_done_q <= 1'b1;
      end else if (rep_q != '1) begin
        rep_q <= rep_q + 1'b1;
      end
    end else begin
      rep_q        <= '0;
      first_done_q <= 1'b0;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Debounce FSM with registered level and event strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
      case (state_q)
        IDLE: begin
          if (s) begin
            cnt_q   <= '0;
            state_q <= PRESS_W;
          end
        end
        PRESS_W: begin
          if (!s) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (press_done) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            state_q <= HELD;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            cnt_q   <= '0;
            state_q <= REL_W;
          end
        end
        REL_W: begin
          if (s) begin
            cnt_q   <= '0;
            state_q <= HELD;
          end else if (rel_done) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign level_o     = level_q;
  assign pulse_o     = pulse_q;
  assign rel_o       = rel_q;
  assign pulse_nxt_o = pulse_d;

endmodule

// File: rtl/button_conditioner.sv
// Push-button input stage: one independent debounce cell per button plus a
// registered OR of all press strobes.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat while a button is held).
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_rel,
  output logic               any_pulse
);

  logic [NUM_BTN-1:0] pulse_nxt;
  logic               any_pulse_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .raw_i      (btn_raw[g]),
      .level_o    (btn_level[g]),
      .pulse_o    (btn_pulse[g]),
      .rel_o      (btn_rel[g]),
      .pulse_nxt_o(pulse_nxt[g])
    );
  end

  // OR the cells' next-cycle strobes so any_pulse lines up with btn_pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_pulse_q <= 1'b0;
    end else begin
      any_pulse_q <= |pulse_nxt;
    end
  end

  assign any_pulse = any_pulse_q;

endmodule
